// File: rtl/trail_backtrack_controller.sv
// -----------------------------------------------------------------------------
// trail_backtrack_controller
//
// Keeps the assignment trail for the BCP unit. The trail is an explicit stack
// of decisions and implications. On a conflict the controller backtracks
// chronologically: it pops every entry down to and including the most recent
// decision, and then pushes that decision back with its polarity flipped as a
// forced implication.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   decide           push a decision {decide_var, decide_val} (IDLE only)
//   refresh          latch implication_reg/implication_val and push every set
//                    bit, lowest index first (IDLE only)
//   backtrack        conflict: pop to the last decision and flip it (IDLE only)
//   busy             high outside IDLE and UNSAT
//   unassign_valid   one-cycle pulse per popped entry; unassign_var = variable
//   force_valid      one-cycle pulse carrying force_var / force_val
//   level            current decision level
//   trail_count      number of trail entries (equal to the stack pointer)
//   unsat            backtrack requested at level 0 (absorbing until rst)
//   overflow         sticky: a push was refused (trail full or level at max)
// -----------------------------------------------------------------------------
module trail_backtrack_controller #(
   parameter int VAR_NUM   = 8,
   parameter int VAR_LOG   = 3,
   parameter int MAX_LEVEL = 8,
   parameter int LEVEL_LOG = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 decide,
   input  logic [VAR_LOG-1:0]   decide_var,
   input  logic                 decide_val,
   input  logic                 refresh,
   input  logic [VAR_NUM-1:0]   implication_reg,
   input  logic [VAR_NUM-1:0]   implication_val,
   input  logic                 backtrack,
   output logic                 busy,
   output logic                 unassign_valid,
   output logic [VAR_LOG-1:0]   unassign_var,
   output logic                 force_valid,
   output logic [VAR_LOG-1:0]   force_var,
   output logic                 force_val,
   output logic [LEVEL_LOG:0]   level,
   output logic [VAR_LOG:0]     trail_count,
   output logic                 unsat,
   output logic                 overflow
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_POP   = 3'd2,
      ST_FORCE = 3'd3,
      ST_UNSAT = 3'd4
   } state_t;

   typedef struct packed {
      logic [VAR_LOG-1:0] var_idx;
      logic               val;
      logic               is_dec;
   } entry_t;

   // Trail storage. Contents need no reset: only entries below the stack
   // pointer are ever read.
   entry_t trail_mem [VAR_NUM];

   state_t               state_reg,    state_next;
   logic [VAR_LOG:0]     count_reg,    count_next;
   logic [LEVEL_LOG:0]   level_reg,    level_next;
   logic [VAR_NUM-1:0]   shadow_reg,   shadow_next;
   logic [VAR_NUM-1:0]   shadow_val_reg, shadow_val_next;
   logic [VAR_LOG-1:0]   flip_var_reg, flip_var_next;
   logic                 flip_val_reg, flip_val_next;
   logic                 overflow_reg, overflow_next;

   logic                 push_en;
   entry_t               push_entry;
   logic                 trail_full;
   logic                 level_full;
   logic [VAR_LOG-1:0]   top_idx;
   entry_t               top_entry;
   logic [VAR_LOG-1:0]   low_idx;

   assign trail_full = (count_reg == (VAR_LOG+1)'(VAR_NUM));
   assign level_full = (level_reg == (LEVEL_LOG+1)'(MAX_LEVEL));

   // Modulo arithmetic on the low bits gives the right top slot even when
   // the trail is completely full (count = VAR_NUM wraps to index 0 - 1).
   assign top_idx   = count_reg[VAR_LOG-1:0] - 1'b1;
   assign top_entry = trail_mem[top_idx];

   // Lowest set bit of the pending implication bitmap.
   always_comb begin
      low_idx = '0;
      for (int i = VAR_NUM - 1; i >= 0; i--) begin
         if (shadow_reg[i]) begin
            low_idx = VAR_LOG'(i);
         end
      end
   end

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         count_reg      <= '0;
         level_reg      <= '0;
         shadow_reg     <= '0;
         shadow_val_reg <= '0;
         flip_var_reg   <= '0;
         flip_val_reg   <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         level_reg      <= level_next;
         shadow_reg     <= shadow_next;
         shadow_val_reg <= shadow_val_next;
         flip_var_reg   <= flip_var_next;
         flip_val_reg   <= flip_val_next;
         overflow_reg   <= overflow_next;
      end
   end

   // Single write port: at most one push happens per cycle.
   always_ff @(posedge clk) begin
      if (push_en && !rst) begin
         trail_mem[count_reg[VAR_LOG-1:0]] <= push_entry;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      count_next      = count_reg;
      level_next      = level_reg;
      shadow_next     = shadow_reg;
      shadow_val_next = shadow_val_reg;
      flip_var_next   = flip_var_reg;
      flip_val_next   = flip_val_reg;
      overflow_next   = overflow_reg;
      push_en         = 1'b0;
      push_entry      = '0;
      unassign_valid  = 1'b0;
      unassign_var    = '0;
      force_valid     = 1'b0;
      force_var       = '0;
      force_val       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // backtrack > refresh > decide; losers are simply dropped.
            if (backtrack) begin
               state_next = (level_reg == '0) ? ST_UNSAT : ST_POP;
            end else if (refresh) begin
               shadow_next     = implication_reg;
               shadow_val_next = implication_val;
               state_next      = ST_SCAN;
            end else if (decide) begin
               if (trail_full || level_full) begin
                  overflow_next = 1'b1;
               end else begin
                  push_en            = 1'b1;
                  push_entry.var_idx = decide_var;
                  push_entry.val     = decide_val;
                  push_entry.is_dec  = 1'b1;
                  count_next         = count_reg + 1'b1;
                  level_next         = level_reg + 1'b1;
               end
            end
         end

         ST_SCAN: begin
            if (shadow_reg != '0) begin
               shadow_next[low_idx] = 1'b0;
               if (trail_full) begin
                  // The entry is lost but the bit is still consumed so the
                  // scan always terminates.
                  overflow_next = 1'b1;
               end else begin
                  push_en            = 1'b1;
                  push_entry.var_idx = low_idx;
                  push_entry.val     = shadow_val_reg[low_idx];
                  push_entry.is_dec  = 1'b0;
                  count_next         = count_reg + 1'b1;
               end
            end
            // Leaving on the cycle of the last push keeps busy at
            // max(1, popcount) cycles.
            if (shadow_next == '0) begin
               state_next = ST_IDLE;
            end
         end

         ST_POP: begin
            if (count_reg == '0) begin
               // No decision left to flip; nothing sensible to pop.
               state_next = ST_IDLE;
            end else begin
               unassign_valid = 1'b1;
               unassign_var   = top_entry.var_idx;
               count_next     = count_reg - 1'b1;
               if (top_entry.is_dec) begin
                  level_next    = level_reg - 1'b1;
                  flip_var_next = top_entry.var_idx;
                  flip_val_next = top_entry.val;
                  state_next    = ST_FORCE;
               end
            end
         end

         ST_FORCE: begin
            // The flipped value goes back as an implication so that it is
            // never flipped a second time. A slot was just freed by the pop,
            // so the trail cannot be full here.
            force_valid        = 1'b1;
            force_var          = flip_var_reg;
            force_val          = ~flip_val_reg;
            push_en            = 1'b1;
            push_entry.var_idx = flip_var_reg;
            push_entry.val     = ~flip_val_reg;
            push_entry.is_dec  = 1'b0;
            count_next         = count_reg + 1'b1;
            state_next         = ST_IDLE;
         end

         ST_UNSAT: begin
            state_next = ST_UNSAT;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_UNSAT);
   assign unsat       = (state_reg == ST_UNSAT);
   assign level       = level_reg;
   assign trail_count = count_reg;
   assign overflow    = overflow_reg;

endmodule

// File: tb/tb_trail_backtrack_controller.sv
module tb_trail_backtrack_controller;

   localparam int VAR_NUM   = 8;
   localparam int VAR_LOG   = 3;
   localparam int MAX_LEVEL = 8;
   localparam int LEVEL_LOG = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 decide;
   logic [VAR_LOG-1:0]   decide_var;
   logic                 decide_val;
   logic                 refresh;
   logic [VAR_NUM-1:0]   implication_reg;
   logic [VAR_NUM-1:0]   implication_val;
   logic                 backtrack;
   logic                 busy;
   logic                 unassign_valid;
   logic [VAR_LOG-1:0]   unassign_var;
   logic                 force_valid;
   logic [VAR_LOG-1:0]   force_var;
   logic                 force_val;
   logic [LEVEL_LOG:0]   level;
   logic [VAR_LOG:0]     trail_count;
   logic                 unsat;
   logic                 overflow;

   int check_count = 0;
   int error_count = 0;

   always #5 clk = ~clk;

   trail_backtrack_controller #(
      .VAR_NUM   (VAR_NUM),
      .VAR_LOG   (VAR_LOG),
      .MAX_LEVEL (MAX_LEVEL),
      .LEVEL_LOG (LEVEL_LOG)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .decide          (decide),
      .decide_var      (decide_var),
      .decide_val      (decide_val),
      .refresh         (refresh),
      .implication_reg (implication_reg),
      .implication_val (implication_val),
      .backtrack       (backtrack),
      .busy            (busy),
      .unassign_valid  (unassign_valid),
      .unassign_var    (unassign_var),
      .force_valid     (force_valid),
      .force_var       (force_var),
      .force_val       (force_val),
      .level           (level),
      .trail_count     (trail_count),
      .unsat           (unsat),
      .overflow        (overflow)
   );

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      check_count++;
      if (obs !== exp) begin
         error_count++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_decide(input int v, input logic val);
      decide     = 1'b1;
      decide_var = VAR_LOG'(v);
      decide_val = val;
      tick();
      decide     = 1'b0;
   endtask

   task automatic do_refresh(input logic [VAR_NUM-1:0] bits, input logic [VAR_NUM-1:0] vals);
      refresh         = 1'b1;
      implication_reg = bits;
      implication_val = vals;
      tick();
      refresh         = 1'b0;
   endtask

   initial begin
      int exp_unassign [4];
      exp_unassign = '{7, 5, 2, 1};

      rst = 1'b1;
      decide = 1'b0; decide_var = '0; decide_val = 1'b0;
      refresh = 1'b0; implication_reg = '0; implication_val = '0;
      backtrack = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // ---- 1. reset state ----
      check("rst_busy", busy, 0);
      check("rst_level", level, 0);
      check("rst_count", trail_count, 0);
      check("rst_unsat", unsat, 0);
      check("rst_overflow", overflow, 0);
      check("rst_unassign_valid", unassign_valid, 0);
      check("rst_force_valid", force_valid, 0);

      // ---- 2. decide + refresh of vars 2,5,7 ----
      do_decide(1, 1'b1);
      check("dec_level", level, 1);
      check("dec_count", trail_count, 1);
      check("dec_busy", busy, 0);
      do_refresh(8'b1010_0100, 8'hFF);
      check("scan_c1_busy", busy, 1);
      check("scan_c1_count", trail_count, 1);
      tick();
      check("scan_c2_busy", busy, 1);
      check("scan_c2_count", trail_count, 2);
      tick();
      check("scan_c3_busy", busy, 1);
      check("scan_c3_count", trail_count, 3);
      tick();
      check("scan_done_busy", busy, 0);
      check("scan_done_count", trail_count, 4);
      check("scan_done_level", level, 1);

      // ---- 3. backtrack: pops 7,5,2,1 then force var 1 val 0 ----
      backtrack = 1'b1;
      tick();
      backtrack = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("pop%0d_valid", k), unassign_valid, 1);
         check($sformatf("pop%0d_var", k), unassign_var, exp_unassign[k]);
         check($sformatf("pop%0d_force_valid", k), force_valid, 0);
         tick();
      end
      check("force_valid", force_valid, 1);
      check("force_unassign_valid", unassign_valid, 0);
      check("force_var", force_var, 1);
      check("force_val", force_val, 0);
      check("force_level", level, 0);
      tick();
      check("bt_done_busy", busy, 0);
      check("bt_done_force_valid", force_valid, 0);
      check("bt_done_count", trail_count, 1);
      check("bt_done_level", level, 0);

      // ---- 4. backtrack at level 0 -> UNSAT, commands ignored ----
      backtrack = 1'b1;
      tick();
      backtrack = 1'b0;
      check("unsat_set", unsat, 1);
      check("unsat_busy", busy, 0);
      do_decide(3, 1'b0);
      check("unsat_decide_count", trail_count, 1);
      check("unsat_decide_level", level, 0);
      check("unsat_sticky", unsat, 1);
      do_reset();
      check("unsat_cleared", unsat, 0);

      // ---- 5a. fill the trail with decides, 9th overflows ----
      for (int v = 0; v < 8; v++) do_decide(v, 1'b0);
      check("fill_level", level, 8);
      check("fill_count", trail_count, 8);
      check("fill_overflow", overflow, 0);
      do_decide(0, 1'b1);
      check("dec9_overflow", overflow, 1);
      check("dec9_count", trail_count, 8);
      check("dec9_level", level, 8);

      // ---- 5b. refresh 0xFF with 6 entries: 2 pushes then overflow ----
      do_reset();
      check("ovf_cleared", overflow, 0);
      for (int v = 0; v < 6; v++) do_decide(v, 1'b1);
      check("six_count", trail_count, 6);
      do_refresh(8'hFF, 8'h00);
      tick();
      check("ovr_c1_count", trail_count, 7);
      check("ovr_c1_overflow", overflow, 0);
      tick();
      check("ovr_c2_count", trail_count, 8);
      check("ovr_c2_overflow", overflow, 0);
      tick();
      check("ovr_c3_overflow", overflow, 1);
      check("ovr_c3_count", trail_count, 8);
      check("ovr_c3_busy", busy, 1);
      for (int c = 0; c < 5; c++) tick();
      check("ovr_done_busy", busy, 0);
      check("ovr_done_count", trail_count, 8);

      // ---- 6a. refresh + backtrack collision: backtrack wins ----
      do_reset();
      do_decide(4, 1'b0);
      refresh         = 1'b1;
      backtrack       = 1'b1;
      implication_reg = 8'h03;
      implication_val = 8'h03;
      tick();
      refresh   = 1'b0;
      backtrack = 1'b0;
      check("col_unassign_valid", unassign_valid, 1);
      check("col_unassign_var", unassign_var, 4);
      tick();
      check("col_force_valid", force_valid, 1);
      check("col_force_var", force_var, 4);
      check("col_force_val", force_val, 1);
      tick();
      check("col_busy", busy, 0);
      check("col_count", trail_count, 1);
      tick();
      check("col_count_later", trail_count, 1);

      // ---- 6b. empty refresh: exactly one busy cycle ----
      do_refresh(8'h00, 8'hFF);
      check("empty_busy_c1", busy, 1);
      check("empty_count_c1", trail_count, 1);
      tick();
      check("empty_busy_c2", busy, 0);
      check("empty_count_c2", trail_count, 1);

      // ---- 1b. reset mid-SCAN with 2 bits pending ----
      do_reset();
      do_refresh(8'h0F, 8'h00);
      tick();
      tick();
      check("midscan_count", trail_count, 2);
      check("midscan_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("midscan_rst_busy", busy, 0);
      check("midscan_rst_count", trail_count, 0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("after_rst_count", trail_count, 0);
      check("after_rst_busy", busy, 0);
      check("after_rst_level", level, 0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
